delta_modulator_seq: RTL

DELTA_MODULATOR_SEQ -- requirements
Module: delta_modulator_seq

---
 rtl/delta_modulator_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/delta_modulator_seq.sv
// Frame-based delta modulator: compares stored samples against a saturating tracking accumulator,
// emitting one bit per sample. Optional adaptive step sizing under `DELTA_ADAPTIVE_STEP_EN.
module delta_modulator_seq #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned STEP     = 1,
  parameter int unsigned MAX_STEP = 16
) (
  input  logic                     CLK100MHZ,
  input  logic                     RST,
  input  logic                     WR_EN,
  input  logic [$clog2(DEPTH)-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]         WR_DATA,
  input  logic                     START,
  output logic                     BUSY,
  output logic                     BIT_OUT,
  output logic                     BIT_VALID,
  output logic [DEPTH-1:0]         BITS,
  output logic                     DONE,
  output logic [WIDTH-1:0]         ACC
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Step arithmetic is wide enough that acc + step never overflows before saturation.
  localparam int unsigned EW = ((WIDTH > 32) ? WIDTH : 32) + 1;
  localparam logic [EW-1:0] STEP_E  = EW'(STEP);
  localparam logic [EW-1:0] ACC_MAX = {{(EW - WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_A  = (AW + 1)'(DEPTH);

  if (DEPTH < 2) begin : g_depth_chk
    $error("DEPTH must be at least 2");
  end
  if (MAX_STEP < STEP) begin : g_step_chk
    $error("MAX_STEP must not be below STEP");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state, w_state_next;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_acc;
  logic [DEPTH-1:0] r_bits;
  logic             r_bit_out;
  logic             r_bit_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_start;
  logic             w_run;
  logic             w_finish;
  logic             w_wr_ok;
  logic             w_wr;
  logic             w_bit;
  logic [EW-1:0]    w_step;
  logic [EW-1:0]    w_acc_e;
  logic [EW-1:0]    w_sum;
  logic [EW-1:0]    w_diff;
  logic [WIDTH-1:0] w_acc_next;

  // FSM: state register
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (START) w_state_next = StRun;
      StRun:   if (r_idx == LAST_IDX) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: control outputs
  always_comb begin
    w_start  = 1'b0;
    w_run    = 1'b0;
    w_finish = 1'b0;
    w_wr_ok  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_start = START;
        w_wr_ok = 1'b1;
      end
      StRun:   w_run    = 1'b1;
      StDone:  w_finish = 1'b1;
      default: ;
    endcase
  end

  // Sample memory has no reset so frames can be replayed after an abort.
  assign w_wr = w_wr_ok && WR_EN && !RST && ({1'b0, WR_ADDR} < DEPTH_A);

  always_ff @(posedge CLK100MHZ) begin
    if (w_wr) begin
      r_mem[WR_ADDR] <= WR_DATA;
    end
  end

`ifdef DELTA_ADAPTIVE_STEP_EN
  localparam logic [EW-1:0] MAX_E = EW'(MAX_STEP);

  logic [EW-1:0] r_step;
  logic          r_prev_bit;
  logic [EW-1:0] w_step_dbl;

  always_comb begin
    w_step_dbl = r_step << 1;
    if (r_idx == '0) begin
      w_step = STEP_E;
    end else if (w_bit == r_prev_bit) begin
      w_step = (w_step_dbl > MAX_E) ? MAX_E : w_step_dbl;
    end else begin
      w_step = STEP_E;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_step     <= STEP_E;
      r_prev_bit <= 1'b0;
    end else if (w_run) begin
      r_step     <= w_step;
      r_prev_bit <= w_bit;
    end
  end
`else
  assign w_step = STEP_E;
`endif

  // Bit decision and saturating accumulator update
  always_comb begin
    w_bit   = r_mem[r_idx] > r_acc;
    w_acc_e = {{(EW - WIDTH){1'b0}}, r_acc};
    w_sum   = w_acc_e + w_step;
    w_diff  = w_acc_e - w_step;
    if (w_bit) begin
      w_acc_next = (w_sum > ACC_MAX) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    end else begin
      w_acc_next = (w_acc_e < w_step) ? '0 : w_diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_bits      <= '0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start) begin
        r_idx  <= '0;
        r_acc  <= '0;
        r_bits <= '0;
      end
      if (w_run) begin
        r_bit_out     <= w_bit;
        r_bit_valid   <= 1'b1;
        r_busy        <= 1'b1;
        r_bits[r_idx] <= w_bit;
        r_acc         <= w_acc_next;
        r_idx         <= r_idx + AW'(1);
      end
      if (w_finish) begin
        r_bit_out   <= 1'b0;
        r_bit_valid <= 1'b0;
        r_busy      <= 1'b0;
      end
    end
  end

  assign BUSY      = r_busy;
  assign BIT_OUT   = r_bit_out;
  assign BIT_VALID = r_bit_valid;
  assign BITS      = r_bits;
  assign DONE      = r_done;
  assign ACC       = r_acc;

endmodule
